// File: rtl/control_unit.sv
// Multicycle control FSM: sequences PC strobes, IR capture, data memory,
// register file and ALU control for a 3-cycle (LOAD: 4-cycle) instruction flow.
module control_unit #(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned D_ADDR_W  = 8,
    parameter int unsigned RF_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 pc_clr,
    output logic                 pc_up,
    output logic [INSTR_W-1:0]   ir_q,
    output logic [D_ADDR_W-1:0]  d_addr,
    output logic                 d_wr,
    output logic                 rf_s,
    output logic [RF_ADDR_W-1:0] rf_w_addr,
    output logic                 rf_w_en,
    output logic [RF_ADDR_W-1:0] rf_ra_addr,
    output logic [RF_ADDR_W-1:0] rf_rb_addr,
    output logic [2:0]           alu_s,
    output logic [3:0]           state_q
);

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned ALU_W   = 3;

    localparam logic [FIELD_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [FIELD_W-1:0] OP_STORE = 4'h1;
    localparam logic [FIELD_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [FIELD_W-1:0] OP_ADD   = 4'h3;
    localparam logic [FIELD_W-1:0] OP_SUB   = 4'h4;
    localparam logic [FIELD_W-1:0] OP_HALT  = 4'h5;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0]   ir_nxt;
    logic [FIELD_W-1:0]   opcode;
    logic [FIELD_W-1:0]   fa, fb, fc;

    logic                 pc_clr_d, pc_up_d, d_wr_d, rf_s_d, rf_w_en_d;
    logic [D_ADDR_W-1:0]  d_addr_d;
    logic [RF_ADDR_W-1:0] rf_w_addr_d, rf_ra_addr_d, rf_rb_addr_d;
    logic [ALU_W-1:0]     alu_s_d;

    assign opcode  = ir_q[INSTR_W-1 -: FIELD_W];
    assign state_q = state;

    // State and instruction register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            ir_q  <= '0;
        end else begin
            state <= state_nxt;
            ir_q  <= ir_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_INIT;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    OP_NOOP:  state_nxt = S_NOOP;
                    default:  state_nxt = S_NOOP;
                endcase
            end
            S_NOOP:   state_nxt = S_FETCH;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            S_ADD:    state_nxt = S_FETCH;
            S_SUB:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // IR only loads on the edge leaving FETCH
    assign ir_nxt = (state == S_FETCH) ? instr : ir_q;
    assign fa     = ir_nxt[INSTR_W-FIELD_W-1 -: FIELD_W];
    assign fb     = ir_nxt[INSTR_W-2*FIELD_W-1 -: FIELD_W];
    assign fc     = ir_nxt[FIELD_W-1:0];

    // Control decode of the upcoming state, registered below so each output
    // matches the state it belongs to in the same cycle
    always_comb begin
        pc_clr_d     = 1'b0;
        pc_up_d      = 1'b0;
        d_addr_d     = '0;
        d_wr_d       = 1'b0;
        rf_s_d       = 1'b0;
        rf_w_addr_d  = '0;
        rf_w_en_d    = 1'b0;
        rf_ra_addr_d = '0;
        rf_rb_addr_d = '0;
        alu_s_d      = ALU_PASS;
        case (state_nxt)
            S_INIT:  pc_clr_d = 1'b1;
            S_FETCH: pc_up_d  = 1'b1;
            S_LOAD_A, S_LOAD_B: begin
                d_addr_d    = D_ADDR_W'({fa, fb});
                rf_s_d      = 1'b1;
                rf_w_addr_d = RF_ADDR_W'(fc);
                rf_w_en_d   = (state_nxt == S_LOAD_B);
            end
            S_STORE: begin
                d_addr_d     = D_ADDR_W'({fa, fb});
                rf_ra_addr_d = RF_ADDR_W'(fc);
                d_wr_d       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_d = RF_ADDR_W'(fa);
                rf_rb_addr_d = RF_ADDR_W'(fb);
                alu_s_d      = (state_nxt == S_ADD) ? ALU_ADD : ALU_SUB;
                rf_w_addr_d  = RF_ADDR_W'(fc);
                rf_w_en_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers; async reset drops write enables and raises pc_clr at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_clr     <= 1'b1;
            pc_up      <= 1'b0;
            d_addr     <= '0;
            d_wr       <= 1'b0;
            rf_s       <= 1'b0;
            rf_w_addr  <= '0;
            rf_w_en    <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
            alu_s      <= ALU_PASS;
        end else begin
            pc_clr     <= pc_clr_d;
            pc_up      <= pc_up_d;
            d_addr     <= d_addr_d;
            d_wr       <= d_wr_d;
            rf_s       <= rf_s_d;
            rf_w_addr  <= rf_w_addr_d;
            rf_w_en    <= rf_w_en_d;
            rf_ra_addr <= rf_ra_addr_d;
            rf_rb_addr <= rf_rb_addr_d;
            alu_s      <= alu_s_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control snapshots are
// queued as stimulus is applied and popped/compared at each falling edge.
module tb_control_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] instr;
    logic        pc_clr, pc_up, d_wr, rf_s, rf_w_en;
    logic [15:0] ir_q;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_q;
    logic [2:0]  alu_s;

    control_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .pc_clr     (pc_clr),
        .pc_up      (pc_up),
        .ir_q       (ir_q),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .state_q    (state_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ir;
        logic        pc_clr;
        logic        pc_up;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  wa;
        logic        we;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Quiet snapshot: only INIT and FETCH carry a PC strobe
    function automatic exp_t base(input logic [3:0] st, input logic [15:0] ir);
        exp_t e;
        e        = '0;
        e.st     = st;
        e.ir     = ir;
        e.pc_clr = (st == 4'd0);
        e.pc_up  = (st == 4'd1);
        return e;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s %s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
            return;
        end
        e = q.pop_front();
        cmp(tag, "state",  32'(state_q),    32'(e.st));
        cmp(tag, "ir",     32'(ir_q),       32'(e.ir));
        cmp(tag, "pc_clr", 32'(pc_clr),     32'(e.pc_clr));
        cmp(tag, "pc_up",  32'(pc_up),      32'(e.pc_up));
        cmp(tag, "d_addr", 32'(d_addr),     32'(e.d_addr));
        cmp(tag, "d_wr",   32'(d_wr),       32'(e.d_wr));
        cmp(tag, "rf_s",   32'(rf_s),       32'(e.rf_s));
        cmp(tag, "w_addr", 32'(rf_w_addr),  32'(e.wa));
        cmp(tag, "w_en",   32'(rf_w_en),    32'(e.we));
        cmp(tag, "ra",     32'(rf_ra_addr), 32'(e.ra));
        cmp(tag, "rb",     32'(rf_rb_addr), 32'(e.rb));
        cmp(tag, "alu_s",  32'(alu_s),      32'(e.alu));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_now(tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) step(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset_n = 1'b0;
        instr   = 16'h0000;

        // Reset held, then released: one INIT cycle, then FETCH
        @(negedge clk);
        q.push_back(base(4'd0, 16'h0000));
        check_now("reset_held");
        reset_n = 1'b1;
        #1;
        q.push_back(base(4'd0, 16'h0000));
        check_now("init");
        instr = 16'h3125;
        q.push_back(base(4'd1, 16'h0000));
        step("fetch0");

        // ADD r5 = r1 + r2
        q.push_back(base(4'd2, 16'h3125));
        e = base(4'd7, 16'h3125);
        e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd5; e.alu = 3'b001; e.we = 1'b1;
        q.push_back(e);
        q.push_back(base(4'd1, 16'h3125));
        drain("add");

        // LOAD r7 <- mem[A3]
        instr = 16'h2A37;
        q.push_back(base(4'd2, 16'h2A37));
        e = base(4'd4, 16'h2A37);
        e.d_addr = 8'hA3; e.rf_s = 1'b1; e.wa = 4'd7;
        q.push_back(e);
        e.st = 4'd5; e.we = 1'b1;
        q.push_back(e);
        q.push_back(base(4'd1, 16'h2A37));
        drain("load");

        // STORE mem[A3] <- r12
        instr = 16'h1A3C;
        q.push_back(base(4'd2, 16'h1A3C));
        e = base(4'd6, 16'h1A3C);
        e.d_addr = 8'hA3; e.ra = 4'd12; e.d_wr = 1'b1;
        q.push_back(e);
        q.push_back(base(4'd1, 16'h1A3C));
        drain("store");

        // HALT holds with no PC strobes even when instr changes
        instr = 16'h5000;
        q.push_back(base(4'd2, 16'h5000));
        step("halt_dec");
        instr = 16'hF123;
        for (int i = 0; i < 22; i++) q.push_back(base(4'd9, 16'h5000));
        drain("halt");

        // Reset out of HALT, then unknown opcode behaves as NOOP
        reset_n = 1'b0;
        #1;
        q.push_back(base(4'd0, 16'h0000));
        check_now("halt_reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        q.push_back(base(4'd0, 16'h0000));
        check_now("init2");
        q.push_back(base(4'd1, 16'h0000));
        q.push_back(base(4'd2, 16'hF123));
        q.push_back(base(4'd3, 16'hF123));
        q.push_back(base(4'd1, 16'hF123));
        drain("noop");

        // Reset asserted mid LOAD_B must drop rf_w_en immediately
        instr = 16'h2A37;
        q.push_back(base(4'd2, 16'h2A37));
        e = base(4'd4, 16'h2A37);
        e.d_addr = 8'hA3; e.rf_s = 1'b1; e.wa = 4'd7;
        q.push_back(e);
        e.st = 4'd5; e.we = 1'b1;
        q.push_back(e);
        drain("load2");
        #2;
        reset_n = 1'b0;
        #1;
        q.push_back(base(4'd0, 16'h0000));
        check_now("mid_reset");
        @(negedge clk);
        q.push_back(base(4'd0, 16'h0000));
        check_now("mid_reset_hold");
        reset_n = 1'b1;
        q.push_back(base(4'd1, 16'h0000));
        step("fetch_after_reset");
        q.push_back(base(4'd2, 16'h2A37));
        e = base(4'd4, 16'h2A37);
        e.d_addr = 8'hA3; e.rf_s = 1'b1; e.wa = 4'd7;
        q.push_back(e);
        e.st = 4'd5; e.we = 1'b1;
        q.push_back(e);
        q.push_back(base(4'd1, 16'h2A37));
        drain("load3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
